// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for a 5-stage IF/ID/EX/MEM/WB core.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   rs1/rs2_raddr_id_i, *_used  ID source operands
//   jump_decision_id_i          JAL redirect from ID
//   regfile_waddr_ex_i, mem_*   EX destination / memory op kind
//   branch_taken_ex_i           branch/JALR taken in EX
//   dmem_req_mem_i, dmem_rvalid_i  MEM stage data access handshake
//   halt_req_i, resume_i        debug halt (level) / resume (pulse)
//   stall_*_o, clear_*_o        combinational per-stage hold / NOP insert
//   halted_o, mem_timeout_o     registered status
//   stall_cnt_o, flush_cnt_o    registered performance counters
module pipeline_ctrl #(
  parameter int unsigned MEM_TIMEOUT  = 16,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           rs1_raddr_id_i,
  input  logic [4:0]           rs2_raddr_id_i,
  input  logic                 rs1_used_id_i,
  input  logic                 rs2_used_id_i,
  input  logic                 jump_decision_id_i,
  input  logic [4:0]           regfile_waddr_ex_i,
  input  logic                 mem_req_ex_i,
  input  logic                 mem_we_ex_i,
  input  logic                 branch_taken_ex_i,
  input  logic                 dmem_req_mem_i,
  input  logic                 dmem_rvalid_i,
  input  logic                 halt_req_i,
  input  logic                 resume_i,
  output logic                 stall_if_o,
  output logic                 stall_id_o,
  output logic                 stall_ex_o,
  output logic                 stall_mem_o,
  output logic                 clear_id_o,
  output logic                 clear_ex_o,
  output logic                 clear_wb_o,
  output logic                 halted_o,
  output logic                 mem_timeout_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic [CNT_WIDTH-1:0] flush_cnt_o
);

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {RUN, MEM_WAIT, DRAIN, HALTED, ERROR} state_t;

  state_t        state, next_state;
  logic [DW-1:0] drain_cnt, drain_cnt_d;
  logic [TW-1:0] tmo_cnt, tmo_cnt_d;
  logic          drain_act, drain_act_d;
  logic          flush_inc;
  logic          load_use, mem_wait, in_drain, redirect;

  assign load_use = mem_req_ex_i & ~mem_we_ex_i & (regfile_waddr_ex_i != 5'd0) &
                    ((rs1_used_id_i & (rs1_raddr_id_i == regfile_waddr_ex_i)) |
                     (rs2_used_id_i & (rs2_raddr_id_i == regfile_waddr_ex_i)));
  assign mem_wait = dmem_req_mem_i & ~dmem_rvalid_i;

  // Next-state and per-stage control
  always_comb begin
    stall_if_o  = 1'b0;
    stall_id_o  = 1'b0;
    stall_ex_o  = 1'b0;
    stall_mem_o = 1'b0;
    clear_id_o  = 1'b0;
    clear_ex_o  = 1'b0;
    clear_wb_o  = 1'b0;
    next_state  = state;
    drain_cnt_d = drain_cnt;
    tmo_cnt_d   = '0;
    drain_act_d = drain_act;
    flush_inc   = 1'b0;
    // a MEM_WAIT entered from DRAIN keeps the drain alive across the wait
    in_drain    = (state == DRAIN) | ((state == MEM_WAIT) & drain_act);
    redirect    = branch_taken_ex_i | (jump_decision_id_i & ~load_use);

    if (rst) begin
      clear_id_o = 1'b1;
      clear_ex_o = 1'b1;
      clear_wb_o = 1'b1;
    end else begin
      case (state)
        ERROR: begin
          stall_if_o  = 1'b1;
          stall_id_o  = 1'b1;
          stall_ex_o  = 1'b1;
          stall_mem_o = 1'b1;
          clear_wb_o  = 1'b1;
          tmo_cnt_d   = tmo_cnt;
        end
        HALTED: begin
          stall_if_o  = 1'b1;
          stall_id_o  = 1'b1;
          clear_ex_o  = 1'b1;
          drain_act_d = 1'b0;
          if (resume_i) next_state = RUN;
        end
        default: begin
          if (mem_wait) begin
            // freeze everything up to MEM, bubble into WB; drain counter paused
            stall_if_o  = 1'b1;
            stall_id_o  = 1'b1;
            stall_ex_o  = 1'b1;
            stall_mem_o = 1'b1;
            clear_wb_o  = 1'b1;
            tmo_cnt_d   = tmo_cnt + TW'(1);
            next_state  = (tmo_cnt_d == TW'(MEM_TIMEOUT)) ? ERROR : MEM_WAIT;
          end else begin
            if (in_drain) begin
              stall_if_o = 1'b1;
              clear_id_o = 1'b1;
            end
            if (branch_taken_ex_i) begin
              stall_if_o = 1'b0;
              clear_id_o = 1'b1;
              clear_ex_o = 1'b1;
              flush_inc  = 1'b1;
            end else if (load_use) begin
              // ID must keep its instruction, so no ID clear even while draining
              stall_if_o = 1'b1;
              stall_id_o = 1'b1;
              clear_id_o = 1'b0;
              clear_ex_o = 1'b1;
            end else if (jump_decision_id_i) begin
              stall_if_o = 1'b0;
              clear_id_o = 1'b1;
              flush_inc  = 1'b1;
            end

            if (in_drain) begin
              if (redirect) begin
                drain_cnt_d = '0;
                next_state  = DRAIN;
                drain_act_d = 1'b1;
              end else if (drain_cnt == DW'(DRAIN_CYCLES - 1)) begin
                drain_cnt_d = '0;
                next_state  = HALTED;
                drain_act_d = 1'b0;
              end else begin
                drain_cnt_d = drain_cnt + DW'(1);
                next_state  = DRAIN;
                drain_act_d = 1'b1;
              end
            end else if (halt_req_i) begin
              drain_cnt_d = '0;
              next_state  = DRAIN;
              drain_act_d = 1'b1;
            end else begin
              next_state  = RUN;
              drain_act_d = 1'b0;
            end
          end
        end
      endcase
    end
  end

  // State, status and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      drain_cnt     <= '0;
      tmo_cnt       <= '0;
      drain_act     <= 1'b0;
      halted_o      <= 1'b0;
      mem_timeout_o <= 1'b0;
      stall_cnt_o   <= '0;
      flush_cnt_o   <= '0;
    end else begin
      state         <= next_state;
      drain_cnt     <= drain_cnt_d;
      tmo_cnt       <= tmo_cnt_d;
      drain_act     <= drain_act_d;
      halted_o      <= (next_state == HALTED);
      mem_timeout_o <= mem_timeout_o | (next_state == ERROR);
      if (stall_if_o) stall_cnt_o <= stall_cnt_o + CNT_WIDTH'(1);
      if (flush_inc)  flush_cnt_o <= flush_cnt_o + CNT_WIDTH'(1);
    end
  end

endmodule
